// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with configurable pattern/length, match counting and
// an IDLE/SCAN/DONE control FSM. Detection is non-overlapping; out is a Mealy pulse.
module seq_detect_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pattern,
    input  logic [2:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in,
    input  logic             in_valid,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [7:0]       pattern;
    logic [2:0]       len;
    logic [CNT_W-1:0] target;
    logic [6:0]       history;
    logic [2:0]       fill;

    logic [7:0]       window;
    logic [7:0]       mask;
    logic             hit;
    logic [CNT_W-1:0] count_inc;

    // Newest bit sits at window[0], matching pattern[0] being the last bit received.
    assign window    = {history, in};
    assign mask      = 8'hFF >> (3'd7 - len);
    assign hit       = (state == SCAN) && in_valid && (fill >= len) &&
                       (((window ^ pattern) & mask) == 8'h00);
    assign out       = hit;
    assign count_inc = (match_count == {CNT_W{1'b1}}) ? match_count : match_count + CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            match_count <= '0;
            history     <= '0;
            fill        <= '0;
            pattern     <= 8'b0000_0101;
            len         <= 3'd2;
            target      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cfg_we) begin
                        pattern <= cfg_pattern;
                        len     <= cfg_len;
                        target  <= cfg_target;
                    end
                    if (start && !abort) begin
                        state       <= SCAN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        match_count <= '0;
                        history     <= '0;
                        fill        <= '0;
                    end else if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (cfg_we) begin
                        err <= 1'b1;
                    end
                    // Abort outranks everything, including a match landing this cycle.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (in_valid) begin
                        if (hit) begin
                            history     <= '0;
                            fill        <= '0;
                            match_count <= count_inc;
                            if ((target != '0) && (count_inc == target)) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            history <= {history[5:0], in};
                            if (fill != 3'd7) begin
                                fill <= fill + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
